// File: rtl/sprite_scanner.sv
// sprite_scanner: drives a row-multiplexed LED matrix from a flat sprite bus.
// Each frame composes a background sprite with an optional right-shifted
// overlay sprite. Every row is lit for ROW_HOLD cycles and then blanked for
// one cycle. Sprite selects and the overlay shift are latched at frame start.
//
// The FSM state is visible on the busy output (high outside IDLE).
module sprite_scanner #(
  parameter int IMAGE_COUNT  = 3,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int SEL_W        = 2,
  parameter int ROW_HOLD     = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [IMAGE_COUNT*IMAGE_WIDTH*IMAGE_HEIGHT-1:0] image,
  input  logic                                        enable,
  input  logic [SEL_W-1:0]                            bg_sel,
  input  logic [SEL_W-1:0]                            ov_sel,
  input  logic                                        ov_en,
  input  logic [$clog2(IMAGE_WIDTH)-1:0]              ov_shift,
  output logic [IMAGE_HEIGHT-1:0]                     row_sel,
  output logic [IMAGE_WIDTH-1:0]                      col_data,
  output logic                                        frame_done,
  output logic                                        busy
);

  localparam int TOTAL   = IMAGE_COUNT * IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int IDX_W   = $clog2(TOTAL);
  localparam int RW      = $clog2(IMAGE_HEIGHT);
  localparam int SH_W    = $clog2(IMAGE_WIDTH);
  localparam int HOLD_W  = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;

  localparam logic [RW-1:0]     LAST_ROW  = RW'(IMAGE_HEIGHT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROW_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t              state;
  logic [RW-1:0]       row;
  logic [HOLD_W-1:0]   hold;

  // Shadow copies of the frame parameters, refreshed only at frame start.
  logic [SEL_W-1:0]    sh_bg;
  logic [SEL_W-1:0]    sh_ov;
  logic                sh_oven;
  logic [SH_W-1:0]     sh_shift;

  // Row about to be shown and the parameter set it should use.
  logic                fresh;
  logic [RW-1:0]       tgt_row;
  logic [SEL_W-1:0]    c_bg;
  logic [SEL_W-1:0]    c_ov;
  logic                c_oven;
  logic [SH_W-1:0]     c_shift;
  logic [IMAGE_WIDTH-1:0] col_next;

  // One sprite row from the bus; selects past the sprite count read as blank.
  function automatic logic [IMAGE_WIDTH-1:0] sprite_row(
    input logic [TOTAL-1:0] img,
    input logic [SEL_W-1:0] sel,
    input logic [RW-1:0]    r
  );
    logic [IDX_W-1:0] base;
    sprite_row = '0;
    base = IDX_W'(int'(sel) * IMAGE_WIDTH * IMAGE_HEIGHT + int'(r) * IMAGE_WIDTH);
    if (int'(sel) < IMAGE_COUNT) sprite_row = img[base +: IMAGE_WIDTH];
  endfunction

  // Pick the target row and parameter set, then compose its column pattern.
  always_comb begin
    fresh   = (state == IDLE) || ((state == BLANK) && (row == LAST_ROW));
    tgt_row = row;
    if (fresh)               tgt_row = '0;
    else if (state == BLANK) tgt_row = row + RW'(1);
    c_bg    = fresh ? bg_sel   : sh_bg;
    c_ov    = fresh ? ov_sel   : sh_ov;
    c_oven  = fresh ? ov_en    : sh_oven;
    c_shift = fresh ? ov_shift : sh_shift;
    col_next = sprite_row(image, c_bg, tgt_row);
    if (c_oven) col_next = col_next | (sprite_row(image, c_ov, tgt_row) >> c_shift);
  end

  // Scan FSM with registered outputs; blank cycle separates consecutive rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      hold       <= '0;
      sh_bg      <= '0;
      sh_ov      <= '0;
      sh_oven    <= 1'b0;
      sh_shift   <= '0;
      row_sel    <= '0;
      col_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= SCAN;
            row      <= '0;
            hold     <= '0;
            sh_bg    <= bg_sel;
            sh_ov    <= ov_sel;
            sh_oven  <= ov_en;
            sh_shift <= ov_shift;
            row_sel  <= IMAGE_HEIGHT'(1) << tgt_row;
            col_data <= col_next;
            busy     <= 1'b1;
          end else begin
            row_sel  <= '0;
            col_data <= '0;
            busy     <= 1'b0;
          end
        end
        SCAN: begin
          if (!enable) begin
            state    <= IDLE;
            row      <= '0;
            hold     <= '0;
            row_sel  <= '0;
            col_data <= '0;
            busy     <= 1'b0;
          end else if (hold == HOLD_LAST) begin
            state      <= BLANK;
            hold       <= '0;
            row_sel    <= '0;
            col_data   <= '0;
            frame_done <= (row == LAST_ROW);
          end else begin
            hold     <= hold + HOLD_W'(1);
            col_data <= col_next;
          end
        end
        BLANK: begin
          if (!enable) begin
            state    <= IDLE;
            row      <= '0;
            hold     <= '0;
            row_sel  <= '0;
            col_data <= '0;
            busy     <= 1'b0;
          end else begin
            state    <= SCAN;
            row      <= tgt_row;
            hold     <= '0;
            row_sel  <= IMAGE_HEIGHT'(1) << tgt_row;
            col_data <= col_next;
            if (row == LAST_ROW) begin
              sh_bg    <= bg_sel;
              sh_ov    <= ov_sel;
              sh_oven  <= ov_en;
              sh_shift <= ov_shift;
            end
          end
        end
        default: begin
          state    <= IDLE;
          row_sel  <= '0;
          col_data <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
